memory_arbiter: RTL
===================

# memory_arbiter

Arbitrates the single-ported unified RAM between the instruction-fetch and data-access request paths of the pipelined processor. Sits between the datapath/cache side and the RAM model. Grants one requester at a time and holds the grant until the RAM reports completion. Data has priority, bounded by a starvation limit that guarantees instruction fetch progress. After the datapath halts, instruction fetch is blocked and outstanding data traffic drains.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants issued while an instruction request is pending; range 1-7.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-high
- halt  in  1  datapath halted; sticky from the datapath
- iREN  in  1  instruction read request
- iaddr  in  32  instruction byte address
- iwait  out  1  low for exactly the cycle the instruction read completes
- iload  out  32  instruction data; valid when iwait is low
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data byte address
- dstore  in  32  write data
- dwait  out  1  low for exactly the cycle the data access completes
- dload  out  32  read data; valid when dwait is low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  word-aligned RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- busy  out  1  high whenever the FSM is not in ARB_IDLE

## Operation
- FSM states: ARB_IDLE, ARB_IGNT, ARB_DGNT.
- Data request: dreq = dREN | dWEN. Instruction request: ireq = iREN & ~halt.
- Decisions in ARB_IDLE, evaluated in this order:
  - dreq and (ireq=0 or starve<STARVE_LIMIT): go to ARB_DGNT.
  - Otherwise, if ireq: go to ARB_IGNT.
  - Otherwise: stay in ARB_IDLE.
- ARB_DGNT outputs:
  - ramWEN=dWEN; ramREN=dREN&~dWEN, so a write wins if both are asserted.
  - ramaddr={daddr[31:2],2'b00}; ramstore=dstore.
- ARB_IGNT outputs: ramREN=1; ramaddr={iaddr[31:2],2'b00}; ramstore=0.
- Grant-state inputs are live, not latched.
- Transitions from a grant state:
  - ramstate==ACCESS: deassert the granted wait, pass ramload to the granted load port, go to ARB_IDLE next cycle.
  - ramstate==ERROR: wait stays high and the grant is held. The strobes drop for one cycle, then the access is re-issued. A 1-bit retry flag controls this.
  - Granted request withdrawn (dreq or iREN falls, e.g. on a pipeline flush): go to ARB_IDLE next cycle. No completion pulse; strobes drop the same cycle.
- Starvation counter, 3-bit, saturating at STARVE_LIMIT:
  - Incremented on entry to ARB_DGNT when ireq=1.
  - Cleared on entry to ARB_IGNT, and on entry to ARB_DGNT when ireq=0.
- Load ports:
  - iload=ramload in ARB_IGNT, else 0.
  - dload=ramload in ARB_DGNT, else 0.
- halt rising during ARB_IGNT: the fetch in flight completes normally. No new instruction grants are issued afterwards.

## Timing
- Reset (RST=1, asynchronous):
  - state=ARB_IDLE, starve=0, retry=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=dwait=1, iload=dload=0, busy=0.
- RST asserted mid-access: strobes drop immediately. No completion is reported; the requester re-requests after reset.
- Arbitration latency: 1 cycle from a request in ARB_IDLE to strobes on the RAM.
- Completion: the wait goes low combinationally in the same cycle ramstate==ACCESS.
- Turnaround: exactly one ARB_IDLE cycle between consecutive grants, so back-to-back accesses cost RAM latency + 2 cycles.
- Simultaneous ireq and dreq with starve<STARVE_LIMIT: data wins.
- Simultaneous ireq and dreq with starve==STARVE_LIMIT: instruction wins.
- Wait signals never go low outside the granted state, and never for more than one cycle per grant.

## Structure
- arb_state_t (ARB_IDLE/ARB_IGNT/ARB_DGNT) is added to cpu_types_pkg.
- ramstate_t and word_t are reused from cpu_types_pkg.
- No sub-module: the FSM, starvation counter and retry flag live in a single always_ff, with output muxing in one always_comb.

## Test plan
- Reset, then iREN=1, iaddr=0x4, RAM latency 2:
  - ramREN=1, ramaddr=0x4 on cycle 1.
  - iwait low on cycle 3 with iload=ramload.
  - busy low on cycle 4.
- iREN=dREN=1 held continuously, STARVE_LIMIT=4, data re-requesting every turnaround: grant sequence is D,D,D,D,I,D,D,D,D,I.
- dREN=dWEN=1, daddr=0x1003, dstore=0xDEADBEEF: ramWEN=1, ramREN=0, ramaddr=0x1000, ramstore=0xDEADBEEF.
- Grant active, ramstate=ERROR for one cycle: strobes low for one cycle, then re-issued; dwait stays high until ACCESS.
- dREN drops mid-grant: next cycle is ARB_IDLE, no dwait pulse; a pending iREN is granted the cycle after.
- halt=1 with iREN=1 and no data request: no ramREN ever asserts. RST pulsed mid-access: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared processor types.
//   word_t       32-bit machine word
//   ramstate_t   RAM handshake status reported by the RAM model
//   arb_state_t  memory_arbiter FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single-ported unified RAM between instruction
// fetch and data access. One requester is granted at a time and the grant is
// held until the RAM reports ACCESS. Data wins ties, but after STARVE_LIMIT
// consecutive data grants with a fetch pending the fetch is served.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   halt              datapath halted; blocks new instruction grants
//   iREN/iaddr        instruction read request; iwait/iload response
//   dREN/dWEN/daddr/dstore  data request; dwait/dload response
//   ramREN/ramWEN/ramaddr/ramstore  RAM request; ramload/ramstate response
//   busy              high whenever a grant is active
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        busy
);

  localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

  arb_state_t state;
  logic [2:0] starve;
  logic       retry;   // one-cycle strobe gap after a RAM ERROR

  logic dreq, ireq;
  assign dreq = dREN | dWEN;
  assign ireq = iREN & ~halt;

  // Byte-offset bits are dropped by the word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ARB_IDLE;
      starve <= '0;
      retry  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          retry <= 1'b0;
          if (dreq && (!ireq || starve < LIM)) begin
            state <= ARB_DGNT;
            if (!ireq)             starve <= '0;
            else if (starve < LIM) starve <= starve + 3'd1;
          end else if (ireq) begin
            state  <= ARB_IGNT;
            starve <= '0;
          end
        end
        ARB_DGNT: begin
          if (!dreq || ramstate == ACCESS) begin
            state <= ARB_IDLE;
            retry <= 1'b0;
          end else begin
            retry <= (ramstate == ERROR);
          end
        end
        // Uses iREN rather than ireq so a fetch in flight survives halt.
        ARB_IGNT: begin
          if (!iREN || ramstate == ACCESS) begin
            state <= ARB_IDLE;
            retry <= 1'b0;
          end else begin
            retry <= (ramstate == ERROR);
          end
        end
        default: begin
          state <= ARB_IDLE;
          retry <= 1'b0;
        end
      endcase
    end
  end

  // Grant-state outputs follow the live request inputs, so a withdrawn
  // request drops the strobes in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      ARB_DGNT: begin
        dload = ramload;
        if (!retry) begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = {daddr[31:2], 2'b00};
          ramstore = dstore;
        end
        if (dreq && ramstate == ACCESS) dwait = 1'b0;
      end
      ARB_IGNT: begin
        iload = ramload;
        if (!retry && iREN) begin
          ramREN  = 1'b1;
          ramaddr = {iaddr[31:2], 2'b00};
        end
        if (iREN && ramstate == ACCESS) iwait = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy = (state != ARB_IDLE);

endmodule
